// File: rtl/corescore_uart_tx_arbiter.sv
// corescore_uart_tx_arbiter: round-robin, message-locked arbiter sharing one UART TX byte port among N_REQ requesters
module corescore_uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [7:0]         o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_abort
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [PW-1:0] ptr, gi, pi;
  logic [N_REQ-1:0] pick;
  logic [CW-1:0] cnt;
  logic acc, own_valid, own_last, timeout;
  assign o_req_ready = o_grant & {N_REQ{!o_valid || i_ready}};
  assign acc = |(i_req_valid & o_req_ready);
  assign own_valid = |(i_req_valid & o_grant);
  assign own_last = |(i_req_last & o_grant);
  assign timeout = TIMEOUT > 0 && state == LOCKED && !own_valid && cnt == CW'(TIMEOUT - 1);
  assign pick = N_REQ'(1) << pi;
  always_comb begin
    gi = '0;
    pi = '0;
    for (int k = 0; k < N_REQ; k++)
      if (o_grant[k]) gi = PW'(k);
    for (int k = N_REQ; k >= 1; k--)
      if (i_req_valid[PW'((int'(ptr) + k) % N_REQ)]) pi = PW'((int'(ptr) + k) % N_REQ);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_grant <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_abort <= 1'b0;
      ptr     <= PW'(N_REQ - 1);
      cnt     <= '0;
    end else begin
      o_abort <= timeout;
      if (acc) begin
        o_data  <= i_req_data[8*gi +: 8];
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (|i_req_valid) begin
            o_grant <= pick;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          if ((acc && own_last) || timeout) begin
            o_grant <= '0;
            ptr     <= gi;
            state   <= IDLE;
            cnt     <= '0;
          end else if (acc) begin
            cnt <= '0;
          end else if (!own_valid && cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_corescore_uart_tx_arbiter.sv
// tb_corescore_uart_tx_arbiter: scoreboard bench for the UART TX arbiter
module tb_corescore_uart_tx_arbiter;
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  logic i_rst_n, i_ready, o_valid, o_abort;
  logic [31:0] i_req_data;
  logic [3:0] i_req_valid, i_req_last, o_req_ready, o_grant, fire;
  logic [7:0] o_data;
  logic [8:0] rq [4][$];
  logic [7:0] exp_q [$];
  int checks = 0, passes = 0;

  corescore_uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_data(i_req_data), .i_req_valid(i_req_valid),
    .i_req_last(i_req_last), .o_req_ready(o_req_ready), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_grant(o_grant), .o_abort(o_abort)
  );

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic wait_idle(string n);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = exp_q.size() == 0 && !o_valid && o_grant == 4'b0 &&
             rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0;
    end
    chk(n, 32'(done), 32'd1);
  endtask

  initial begin
    i_req_valid = '0;
    i_req_last = '0;
    i_req_data = '0;
    fire = '0;
    forever begin
      @(negedge i_clk);
      for (int k = 0; k < 4; k++) begin
        if (fire[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        if (rq[k].size() > 0) begin
          i_req_valid[k] = 1'b1;
          i_req_last[k] = rq[k][0][8];
          i_req_data[8*k +: 8] = rq[k][0][7:0];
        end else begin
          i_req_valid[k] = 1'b0;
          i_req_last[k] = 1'b0;
          i_req_data[8*k +: 8] = 8'h00;
        end
      end
      #2 fire = i_req_valid & o_req_ready;
    end
  end

  initial forever begin
    @(negedge i_clk);
    #3;
    if (i_rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_byte: got %02h, no byte expected", o_data);
      end else begin
        chk("byte", 32'(o_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int n;
    i_rst_n = 1'b0;
    i_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_abort", 32'(o_abort), 0);
    chk("rst_ready", 32'(o_req_ready), 0);
    i_rst_n = 1'b1;
    tick();
    // 1: single message from req0, latency and grant
    rq[0].push_back({1'b0, 8'h41}); rq[0].push_back({1'b0, 8'h42}); rq[0].push_back({1'b1, 8'h43});
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    tick();
    chk("t1_c0_grant", 32'(o_grant), 0);
    tick();
    chk("t1_c1_grant", 32'(o_grant), 1);
    chk("t1_c1_valid", 32'(o_valid), 0);
    tick();
    chk("t1_c2_valid", 32'(o_valid), 1);
    chk("t1_c2_data", 32'(o_data), 32'h41);
    tick();
    chk("t1_c3_data", 32'(o_data), 32'h42);
    tick();
    chk("t1_c4_data", 32'(o_data), 32'h43);
    chk("t1_c4_grant", 32'(o_grant), 0);
    wait_idle("t1_drain");
    // 2: req1 and req3 contest, then ptr=1 contest
    rq[1].push_back({1'b0, 8'h11}); rq[1].push_back({1'b1, 8'h12});
    rq[3].push_back({1'b0, 8'h31}); rq[3].push_back({1'b1, 8'h32});
    exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    tick(); tick();
    chk("t2_grant_a", 32'(o_grant), 32'h2);
    wait_idle("t2_drain_a");
    rq[1].push_back({1'b1, 8'h13});
    exp_q.push_back(8'h13);
    wait_idle("t2_drain_b");
    rq[3].push_back({1'b0, 8'h33}); rq[3].push_back({1'b1, 8'h34});
    rq[1].push_back({1'b0, 8'h14}); rq[1].push_back({1'b1, 8'h15});
    exp_q.push_back(8'h33); exp_q.push_back(8'h34); exp_q.push_back(8'h14); exp_q.push_back(8'h15);
    tick(); tick();
    chk("t2_grant_c", 32'(o_grant), 32'h8);
    wait_idle("t2_drain_c");
    // 3: all requesters continuously valid, one-byte messages, starting after req3 served
    rq[3].push_back({1'b1, 8'h35});
    exp_q.push_back(8'h35);
    wait_idle("t3_pre");
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < 4; k++) begin
        rq[k].push_back({1'b1, 8'(k * 16 + j)});
        exp_q.push_back(8'(k * 16 + j));
      end
    tick(); tick();
    chk("t3_grant", 32'(o_grant), 1);
    wait_idle("t3_drain");
    // 4: emitter backpressure mid-message
    for (int i = 1; i <= 5; i++) begin
      rq[0].push_back({i == 5, 8'(8'h60 + i)});
      exp_q.push_back(8'(8'h60 + i));
    end
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      found = o_valid && o_data == 8'h62;
    end
    chk("t4_reach", 32'(found), 1);
    i_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_data", 32'(o_data), 32'h62);
      chk("t4_hold_ready", 32'(o_req_ready), 0);
    end
    i_ready = 1'b1;
    wait_idle("t4_drain");
    // 5: watchdog release of stalled req2, pending req0 next
    rq[2].push_back({1'b0, 8'h10});
    rq[0].push_back({1'b1, 8'h01});
    exp_q.push_back(8'h10); exp_q.push_back(8'h01);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      found = o_valid && o_data == 8'h10;
    end
    chk("t5_reach", 32'(found), 1);
    n = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      n++;
      found = o_abort;
    end
    chk("t5_abort_lat", 32'(n), 8);
    chk("t5_abort_grant", 32'(o_grant), 0);
    tick();
    chk("t5_abort_pulse", 32'(o_abort), 0);
    chk("t5_next_grant", 32'(o_grant), 1);
    wait_idle("t5_drain");
    // 6: async reset mid-message
    i_ready = 1'b0;
    rq[1].push_back({1'b0, 8'h71}); rq[1].push_back({1'b0, 8'h72}); rq[1].push_back({1'b1, 8'h73});
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      found = o_valid;
    end
    chk("t6_reach", 32'(found), 1);
    #3 i_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(o_valid), 0);
    chk("t6_rst_grant", 32'(o_grant), 0);
    for (int k = 0; k < 4; k++) rq[k].delete();
    exp_q.delete();
    tick(); tick();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    rq[0].push_back({1'b1, 8'h81});
    rq[2].push_back({1'b1, 8'h82});
    exp_q.push_back(8'h81); exp_q.push_back(8'h82);
    tick(); tick();
    chk("t6_first_grant", 32'(o_grant), 1);
    wait_idle("t6_drain");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
